bignum_stream_adder: RTL
========================

BIGNUM_STREAM_ADDER -- requirements
Module: bignum_stream_adder

Interface
REQ-001 The module SHALL have parameter REGISTER_SIZE, default 32, giving the block width in bits.
REQ-002 The module SHALL have parameter NUM_BLOCKS, default 256, giving the operand length in blocks, least-significant block first.
REQ-003 The module SHALL have port clk_in, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port valid_in, input, 1 bit: a_block_in and b_block_in carry one aligned block pair this cycle.
REQ-006 The module SHALL have port a_block_in, input, REGISTER_SIZE bits: operand A block.
REQ-007 The module SHALL have port b_block_in, input, REGISTER_SIZE bits: operand B block.
REQ-008 The module SHALL have port ready_out, output, 1 bit: the module accepts a block pair this cycle.
REQ-009 The module SHALL have port valid_out, output, 1 bit: data_block_out holds a sum block.
REQ-010 The module SHALL have port data_block_out, output, REGISTER_SIZE bits: sum block, least-significant block first.
REQ-011 The module SHALL have port last_out, output, 1 bit: the current output block is the final block of the sum.
REQ-012 The module SHALL have port carry_out, output, 1 bit: final carry of the sum, meaningful only while last_out is high.

Function
REQ-013 A block pair SHALL be accepted exactly on cycles where valid_in and ready_out are both high; valid_in while ready_out is low SHALL be ignored.
REQ-014 For each accepted pair, the module SHALL compute a_block_in + b_block_in + carry at REGISTER_SIZE+1 bits, register the low REGISTER_SIZE bits on data_block_out, and register the top bit into the internal carry.
REQ-015 Latency SHALL be one cycle: valid_out is high in the cycle after each accepted pair and low otherwise, except for the carry block of REQ-021.
REQ-016 Internal carry SHALL be zero before the first block of every operand and SHALL hold its value across cycles with valid_in low.
REQ-017 The block counter SHALL count accepted pairs from 0 to NUM_BLOCKS-1; the pair accepted at count NUM_BLOCKS-1 SHALL end the operand.
REQ-018 FSM states SHALL be ACCEPT and CARRY; ACCEPT is the reset state, with ready_out high in ACCEPT and low in CARRY.
REQ-019 When the macro is absent, the final pair SHALL produce an output block with last_out=1 and carry_out equal to the final carry; the counter and carry SHALL then clear and the FSM SHALL stay in ACCEPT.
REQ-020 Back-to-back operands SHALL be supported with no idle cycle when the macro is absent.
REQ-021 When the macro is present, the final pair SHALL move the FSM to CARRY with last_out=0 on that block; in CARRY the next cycle SHALL output valid_out=1, data_block_out equal to the carry zero-extended, last_out=1, carry_out=0, then clear the counter and carry and return to ACCEPT.
REQ-022 last_out and carry_out SHALL be 0 whenever valid_out is 0.

Reset
REQ-023 On rst_in high, the module SHALL set valid_out=0, data_block_out=0, last_out=0, carry_out=0, carry=0, counter=0, FSM=ACCEPT; ready_out SHALL be 1 in the cycle after reset.
REQ-024 Reset mid-operand or in CARRY SHALL abandon the partial sum, and no further output of that operand SHALL appear.
REQ-025 Reset SHALL take priority over valid_in in the same cycle.

Configuration
REQ-026 Macro BIGNUM_ADDER_CARRY_BLOCK_EN: when defined, each sum SHALL be NUM_BLOCKS+1 blocks per REQ-021 and ready_out SHALL drop for one cycle per operand.
REQ-027 When BIGNUM_ADDER_CARRY_BLOCK_EN is undefined, each sum SHALL be NUM_BLOCKS blocks, the carry SHALL appear only on carry_out, and ready_out SHALL be tied to 1.

Verification
REQ-028 With REGISTER_SIZE=32, NUM_BLOCKS=4, A=all-ones, B=1, macro off: output SHALL be 0,0,0,0, last_out and carry_out both high on the 4th block.
REQ-029 With the REQ-028 stimulus and macro on: output SHALL be 0,0,0,0,1, ready_out low exactly one cycle, last_out only on the 5th block.
REQ-030 With blocks A=5,0,0,0 and B=7,0,0,0, valid_in gapped 3 idle cycles between pairs: output SHALL be 12,0,0,0, carry held across gaps, carry_out=0.
REQ-031 For two operands back-to-back with the macro off, first all-ones+1 and then 1,2,3,4+1,1,1,1: output SHALL be 0,0,0,0 then 2,3,4,5 with no bubble, and the second sum SHALL not inherit a carry.
REQ-032 Reset asserted after the 2nd accepted pair, followed by a fresh 4-block operand: the output SHALL contain only the fresh sum, and valid_out SHALL be 0 during reset.
REQ-033 Driving valid_in high with 9,9,9,9 while ready_out is low (in CARRY) SHALL leave that pair unconsumed, and the counter SHALL be unchanged.

Source files
------------

// File: rtl/bignum_stream_adder.sv
// Streaming multi-block adder: sums two NUM_BLOCKS-block operands LS block first, one cycle latency.
// Optional macro BIGNUM_ADDER_CARRY_BLOCK_EN appends the final carry as an extra output block.
module bignum_stream_adder #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 256,
  localparam int CNT_W        = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] a_block_in,
  input  logic [REGISTER_SIZE-1:0] b_block_in,
  output logic                     ready_out,
  output logic                     valid_out,
  output logic [REGISTER_SIZE-1:0] data_block_out,
  output logic                     last_out,
  output logic                     carry_out,
  output logic                     dbg_state_out,
  output logic [CNT_W-1:0]         dbg_count_out
);

  // Handshake: a pair is consumed on a rising edge where valid_in && ready_out;
  // valid_out is a one-cycle pulse per produced block with no backpressure.
  typedef enum logic {ACCEPT = 1'b0, CARRY = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     carry_q, carry_d;
  logic                     valid_q, valid_d;
  logic [REGISTER_SIZE-1:0] data_q, data_d;
  logic                     last_q, last_d;
  logic                     cout_q, cout_d;

  logic [REGISTER_SIZE:0]   sum;
  logic                     is_final;
  logic                     accept;

  assign sum      = {1'b0, a_block_in} + {1'b0, b_block_in} + {{REGISTER_SIZE{1'b0}}, carry_q};
  assign is_final = (count_q == CNT_W'(NUM_BLOCKS - 1));

`ifdef BIGNUM_ADDER_CARRY_BLOCK_EN
  assign ready_out = (state_q == ACCEPT);
`else
  assign ready_out = 1'b1;
`endif

  assign accept = valid_in && ready_out;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    valid_d = 1'b0;
    data_d  = data_q;
    last_d  = 1'b0;
    cout_d  = 1'b0;
    case (state_q)
      ACCEPT: begin
        if (accept) begin
          valid_d = 1'b1;
          data_d  = sum[REGISTER_SIZE-1:0];
          if (is_final) begin
`ifdef BIGNUM_ADDER_CARRY_BLOCK_EN
            // Counter stays at its final value until the carry block leaves.
            carry_d = sum[REGISTER_SIZE];
            state_d = CARRY;
`else
            last_d  = 1'b1;
            cout_d  = sum[REGISTER_SIZE];
            carry_d = 1'b0;
            count_d = '0;
`endif
          end else begin
            carry_d = sum[REGISTER_SIZE];
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: begin
        valid_d = 1'b1;
        data_d  = {{(REGISTER_SIZE-1){1'b0}}, carry_q};
        last_d  = 1'b1;
        carry_d = 1'b0;
        count_d = '0;
        state_d = ACCEPT;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ACCEPT;
      count_q <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
    end
  end

  assign valid_out      = valid_q;
  assign data_block_out = data_q;
  assign last_out       = last_q;
  assign carry_out      = cout_q;
  assign dbg_state_out  = (state_q == CARRY);
  assign dbg_count_out  = count_q;

endmodule
